// File: rtl/input_flit_buffer_if.sv
// Link-side and route-side signals of one router input port, bundled.
// Latency: none, this is wiring only.
// Backpressure: port_block comes from the route stage; buffer_full goes to the upstream router.
interface input_flit_buffer_if #(
  parameter int FLIT_WIDTH = 12,
  parameter int PTR_WIDTH  = 2
);
  logic [FLIT_WIDTH-1:0] in_flit;
  logic                  port_block;
  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  buffer_full;
  logic                  buffer_empty;
  logic [PTR_WIDTH:0]    occupancy;
  logic                  overflow;

  // Link and route stage side: supplies flits and the block signal, observes status.
  modport master (
    output in_flit, port_block,
    input  out_flit, buffer_full, buffer_empty, occupancy, overflow
  );

  // The buffer itself.
  modport slave (
    input  in_flit, port_block,
    output out_flit, buffer_full, buffer_empty, occupancy, overflow
  );
endinterface

// File: rtl/input_flit_buffer.sv
// Per-port ingress flit FIFO feeding the route stage; all-zero flits are idle cycles.
// Latency: 1 cycle from push to head. With FLIT_BUF_BYPASS_EN, an empty buffer cuts through in 0 cycles.
// Backpressure: holds flits while port_block is high, and exports buffer_full as the upstream port_block.
module input_flit_buffer #(
  parameter int FLIT_WIDTH   = 12,
  parameter int BUFFER_DEPTH = 4,
  parameter int PTR_WIDTH    = 2
) (
  input logic             clk,
  input logic             reset,
  input_flit_buffer_if.slave bus
);

  localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(BUFFER_DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

  logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH:0]    count;
  logic                  overflow_q;

  logic in_vld;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic bypass;
  logic drop;

  assign in_vld = |bus.in_flit;
  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);

`ifdef FLIT_BUF_BYPASS_EN
  // An empty buffer with a willing route stage hands the link flit straight through.
  assign bypass = empty && !bus.port_block && in_vld;
`else
  assign bypass = 1'b0;
`endif

  // Pop and push both look at the state before the edge. A flit may enter a full
  // buffer only while the head leaves in the same cycle.
  assign pop  = !empty && !bus.port_block;
  assign push = in_vld && !bypass && (!full || pop);
  assign drop = in_vld && !bypass && full && !pop;

  assign bus.buffer_full  = full;
  assign bus.buffer_empty = empty;
  assign bus.occupancy    = count;
  assign bus.overflow     = overflow_q;

  // Head flit presented to the route stage. Zero when nothing is held, unless cut-through applies.
  always_comb begin
    bus.out_flit = '0;
    if (!empty) begin
      bus.out_flit = mem[rd_ptr];
    end
`ifdef FLIT_BUF_BYPASS_EN
    else if (bypass) begin
      bus.out_flit = bus.in_flit;
    end
`endif
  end

  // Flit storage. No reset is needed because only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= bus.in_flit;
    end
  end

  // Pointers, stored count and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_flit_buffer.sv
// Self-checking bench for input_flit_buffer, built against a queue-based reference model.
// Inputs are driven 1 time unit after the rising edge, and outputs are compared on the falling edge.
// The bench follows FLIT_BUF_BYPASS_EN in the same way the design does.
module tb_input_flit_buffer;
  localparam int FW    = 12;
  localparam int DEPTH = 4;
  localparam int PW    = 2;
`ifdef FLIT_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  input_flit_buffer_if #(.FLIT_WIDTH(FW), .PTR_WIDTH(PW)) bus ();

  input_flit_buffer #(.FLIT_WIDTH(FW), .BUFFER_DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an ordered list of held flits plus the sticky drop flag.
  logic [FW-1:0] model_q[$];
  bit            model_ovf;
  logic [FW-1:0] cur_in;
  bit            cur_pb;

  logic [17:0] dut_status;
  assign dut_status = {bus.out_flit, bus.buffer_full, bus.buffer_empty, bus.occupancy, bus.overflow};

  function automatic logic [FW-1:0] exp_out();
    if (model_q.size() != 0) return model_q[0];
    if (BYP && !cur_pb && cur_in != '0) return cur_in;
    return '0;
  endfunction

  function automatic logic [17:0] exp_status();
    logic full_e, empty_e;
    full_e  = (model_q.size() == DEPTH);
    empty_e = (model_q.size() == 0);
    return {exp_out(), full_e, empty_e, 3'(model_q.size()), model_ovf};
  endfunction

  // Apply inputs for one cycle and wait until the falling edge, where outputs are stable.
  task automatic drive(input logic [FW-1:0] f, input bit pb);
    cur_in = f;
    cur_pb = pb;
    bus.in_flit = f;
    bus.port_block = pb;
    @(negedge clk);
  endtask

  // Take the rising edge and let the model consume the same inputs.
  task automatic tick();
    bit pop, byp;
    @(posedge clk);
    pop = (model_q.size() > 0) && !cur_pb;
    byp = BYP && (model_q.size() == 0) && !cur_pb && (cur_in != '0);
    if (pop) void'(model_q.pop_front());
    if (cur_in != '0 && !byp) begin
      if (model_q.size() < DEPTH) model_q.push_back(cur_in);
      else model_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset(input logic [FW-1:0] f);
    reset = 1'b1;
    bus.in_flit = f;
    bus.port_block = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_flit = '0;
    cur_in = '0;
    cur_pb = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset('0);
    for (int i = 0; i < 3; i++) begin
      drive('0, 1'b0);
      n_checks++;
      if ({bus.out_flit, bus.buffer_empty, bus.occupancy, bus.overflow} !== {12'h000, 1'b1, 3'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got out=%h empty=%b occ=%0d ovf=%b, expected 000/1/0/0",
                 i, bus.out_flit, bus.buffer_empty, bus.occupancy, bus.overflow);
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [FW-1:0] same_exp, next_exp;
    same_exp = BYP ? 12'h92B : 12'h000;
    next_exp = BYP ? 12'h000 : 12'h92B;
    drive(12'h92B, 1'b0);
    n_checks++;
    if (bus.out_flit !== same_exp || bus.occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL single_same_cycle: got out=%h occ=%0d, expected out=%h occ=0", bus.out_flit, bus.occupancy, same_exp);
    end
    tick();
    drive('0, 1'b0);
    n_checks++;
    if (bus.out_flit !== next_exp) begin
      n_fail++;
      $display("FAIL single_next_cycle: got out=%h, expected %h", bus.out_flit, next_exp);
    end
    tick();
    drive('0, 1'b0);
    n_checks++;
    if (bus.out_flit !== 12'h000 || bus.buffer_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_after: got out=%h empty=%b, expected 000/1", bus.out_flit, bus.buffer_empty);
    end
    tick();
  endtask

  task automatic test_fill_overflow();
    do_reset('0);
    for (int i = 0; i < 4; i++) begin
      drive(12'(12'h101 + i), 1'b1);
      tick();
    end
    drive('0, 1'b1);
    n_checks++;
    if ({bus.buffer_full, bus.occupancy, bus.out_flit, bus.overflow} !== {1'b1, 3'd4, 12'h101, 1'b0}) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b occ=%0d out=%h ovf=%b, expected 1/4/101/0",
               bus.buffer_full, bus.occupancy, bus.out_flit, bus.overflow);
    end
    tick();
    drive(12'h105, 1'b1);
    tick();
    drive('0, 1'b1);
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.occupancy !== 3'd4 || bus.out_flit !== 12'h101) begin
      n_fail++;
      $display("FAIL fill_overflow: got ovf=%b occ=%0d out=%h, expected 1/4/101", bus.overflow, bus.occupancy, bus.out_flit);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive('0, 1'b0);
      n_checks++;
      if (bus.out_flit !== 12'(12'h101 + i)) begin
        n_fail++;
        $display("FAIL fill_drain %0d: got %h, expected %h", i, bus.out_flit, 12'(12'h101 + i));
      end
      tick();
    end
    drive('0, 1'b0);
    n_checks++;
    if ({bus.buffer_full, bus.buffer_empty, bus.overflow} !== 3'b011) begin
      n_fail++;
      $display("FAIL fill_drained: got full=%b empty=%b ovf=%b, expected 0/1/1", bus.buffer_full, bus.buffer_empty, bus.overflow);
    end
    tick();
  endtask

  task automatic test_full_push_pop();
    logic [FW-1:0] exp_seq [4] = '{12'h302, 12'h303, 12'h304, 12'h7A1};
    do_reset('0);
    for (int i = 0; i < 4; i++) begin
      drive(12'(12'h301 + i), 1'b1);
      tick();
    end
    drive(12'h7A1, 1'b0);
    n_checks++;
    if (bus.out_flit !== 12'h301 || bus.buffer_full !== 1'b1) begin
      n_fail++;
      $display("FAIL fullpp_head: got out=%h full=%b, expected 301/1", bus.out_flit, bus.buffer_full);
    end
    tick();
    drive('0, 1'b1);
    n_checks++;
    if ({bus.occupancy, bus.overflow, bus.out_flit} !== {3'd4, 1'b0, 12'h302}) begin
      n_fail++;
      $display("FAIL fullpp_after: got occ=%0d ovf=%b out=%h, expected 4/0/302", bus.occupancy, bus.overflow, bus.out_flit);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive('0, 1'b0);
      n_checks++;
      if (bus.out_flit !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL fullpp_drain %0d: got %h, expected %h", i, bus.out_flit, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_stream_toggle();
    int sent;
    logic [FW-1:0] got[$];
    logic [FW-1:0] f;
    bit pb;
    sent = 0;
    do_reset('0);
    for (int cyc = 0; cyc < 100 && got.size() < 10; cyc++) begin
      pb = (cyc % 2 == 0);
      f = (sent < 10 && !bus.buffer_full) ? 12'(12'h201 + sent) : 12'h000;
      drive(f, pb);
      n_checks++;
      if (dut_status !== exp_status()) begin
        n_fail++;
        $display("FAIL stream_status cyc %0d: got %h, expected %h", cyc, dut_status, exp_status());
      end
      if (bus.out_flit != '0 && !pb) got.push_back(bus.out_flit);
      tick();
      if (f != '0) sent++;
    end
    n_checks++;
    if (got.size() != 10) begin
      n_fail++;
      $display("FAIL stream_count: got %0d flits, expected 10", got.size());
    end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== 12'(12'h201 + i)) begin
        n_fail++;
        $display("FAIL stream_order %0d: got %h, expected %h", i, got[i], 12'(12'h201 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset('0);
    for (int i = 0; i < 5; i++) begin
      drive(12'(12'h601 + i), 1'b1);
      tick();
    end
    drive('0, 1'b0);
    tick();
    drive('0, 1'b1);
    n_checks++;
    if (bus.occupancy !== 3'd3 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: got occ=%0d ovf=%b, expected 3/1", bus.occupancy, bus.overflow);
    end
    do_reset(12'h444);
    drive('0, 1'b0);
    n_checks++;
    if ({bus.occupancy, bus.out_flit, bus.buffer_empty, bus.overflow} !== {3'd0, 12'h000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_post: got occ=%0d out=%h empty=%b ovf=%b, expected 0/000/1/0",
               bus.occupancy, bus.out_flit, bus.buffer_empty, bus.overflow);
    end
    tick();
    drive(12'h555, 1'b1);
    tick();
    drive('0, 1'b1);
    n_checks++;
    if (bus.out_flit !== 12'h555 || bus.occupancy !== 3'd1) begin
      n_fail++;
      $display("FAIL midreset_first: got out=%h occ=%0d, expected 555/1", bus.out_flit, bus.occupancy);
    end
    tick();
  endtask

  task automatic test_random();
    logic [FW-1:0] f;
    bit pb;
    do_reset('0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 99) == 0) do_reset(12'($urandom_range(0, 4095)));
      f = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      pb = ($urandom_range(0, 1) == 1);
      drive(f, pb);
      n_checks++;
      if (dut_status !== exp_status()) begin
        n_fail++;
        $display("FAIL random_status cyc %0d: got %h, expected %h", cyc, dut_status, exp_status());
      end
      tick();
    end
  endtask

  initial begin
    bus.in_flit = '0;
    bus.port_block = 1'b0;
    cur_in = '0;
    cur_pb = 1'b0;
    model_ovf = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_stream_toggle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
